// File: rtl/delay_tap_ctrl.sv
// rtl/delay_tap_ctrl.sv - selects one of four delay-line taps and gates the output until the new line has flushed
module delay_tap_ctrl #(
  parameter int DEPTH0 = 30,
  parameter int DEPTH1 = 45,
  parameter int DEPTH2 = 60,
  parameter int DEPTH3 = 90,
  parameter int CNT_W  = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             sel_req_valid,
  input  logic [7:0]       sel_req,
  output logic             sel_ready,
  output logic [1:0]       tap_sel,
  output logic             mute,
  output logic             out_valid,
  output logic             sel_err,
  output logic [CNT_W-1:0] fill_cnt,
  output logic [7:0]       switch_cnt
);

  typedef enum logic {FILL, RUN} state_e;

  state_e           state_q, state_d;
  logic [1:0]       tap_q, tap_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [7:0]       sw_q, sw_d;

  logic [CNT_W-1:0] depth;
  logic             accept;
  logic             legal;
  logic             change;

  always_comb begin
    case (tap_q)
      2'd0:    depth = CNT_W'(DEPTH0);
      2'd1:    depth = CNT_W'(DEPTH1);
      2'd2:    depth = CNT_W'(DEPTH2);
      default: depth = CNT_W'(DEPTH3);
    endcase
  end

  assign accept = sel_req_valid & ena;
  assign legal  = (sel_req < 8'd4);
  assign change = accept & legal & (sel_req[1:0] != tap_q);

  // A legal tap change outranks a fill completing in the same cycle.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    fill_d  = fill_q;
    valid_d = valid_q;
    sw_d    = sw_q;
    err_d   = accept & ~legal;
    if (change) begin
      state_d = FILL;
      tap_d   = sel_req[1:0];
      fill_d  = '0;
      valid_d = 1'b0;
      sw_d    = sw_q + 8'd1;
    end else if (ena && state_q == FILL) begin
      if (fill_q == depth - CNT_W'(1)) begin
        state_d = RUN;
        fill_d  = depth;
        valid_d = 1'b1;
      end else begin
        fill_d = fill_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      tap_q   <= 2'd0;
      fill_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      sw_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      sw_q    <= sw_d;
    end
  end

  assign sel_ready  = ena;
  assign tap_sel    = tap_q;
  assign out_valid  = valid_q;
  assign sel_err    = err_q;
  assign fill_cnt   = fill_q;
  assign switch_cnt = sw_q;
  assign mute       = ~valid_q | ~ena;

endmodule

// File: doc/delay_tap_ctrl.md
DELAY_TAP_CTRL -- requirements
Module: delay_tap_ctrl

Interface
REQ-001 SHALL have parameter DEPTH0, default 30: latency in cycles of delay line 0.
REQ-002 SHALL have parameter DEPTH1, default 45: latency of delay line 1.
REQ-003 SHALL have parameter DEPTH2, default 60: latency of delay line 2.
REQ-004 SHALL have parameter DEPTH3, default 90: latency of delay line 3.
REQ-005 SHALL have parameter CNT_W, default 7: fill counter width; shall satisfy 2^CNT_W > max(DEPTHn).
REQ-006 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-008 SHALL have port ena  input  1: design enable; when low, the block holds and the output is muted.
REQ-009 SHALL have port sel_req_valid  input  1: a tap-select request is present.
REQ-010 SHALL have port sel_req  input  8: requested line index; only 0..3 are legal.
REQ-011 SHALL have port sel_ready  output  1: the block can accept a request this cycle.
REQ-012 SHALL have port tap_sel  output  2: active line index, driving the output mux select.
REQ-013 SHALL have port mute  output  1: forces the mux output to zero.
REQ-014 SHALL have port out_valid  output  1: the mux output is a fully flushed sample of line tap_sel.
REQ-015 SHALL have port sel_err  output  1: one-cycle pulse when an illegal request is accepted.
REQ-016 SHALL have port fill_cnt  output  CNT_W: cycles filled since the last (re)start.
REQ-017 SHALL have port switch_cnt  output  8: count of accepted tap changes, wrapping.

Function
REQ-018 SHALL implement two states: FILL and RUN.
REQ-019 SHALL drive mute = ~out_valid | ~ena combinationally; all other outputs are registered, except sel_ready.
REQ-020 SHALL drive sel_ready = ena in both states.
- A request is accepted on a cycle where sel_req_valid & sel_ready = 1.
REQ-021 In FILL with ena=1, SHALL increment fill_cnt each cycle.
- FILL exits to RUN on the cycle where fill_cnt == DEPTH[tap_sel]-1.
- The transition sets out_valid=1 on the next cycle.
- Result: out_valid rises exactly DEPTH[tap_sel] enabled cycles after FILL entry.
REQ-022 In RUN, SHALL hold fill_cnt saturated at DEPTH[tap_sel] and keep out_valid=1.
REQ-023 SHALL handle an accepted legal request (sel_req <= 3) as follows.
- sel_req != tap_sel: next cycle tap_sel = sel_req, fill_cnt = 0, out_valid = 0, state = FILL, switch_cnt += 1 (wraps 255 -> 0). This applies from either state.
- sel_req == tap_sel: no state, count or flag change in either state.
REQ-024 SHALL handle an accepted illegal request (sel_req > 3) as follows.
- Pulse sel_err for exactly one cycle, the cycle after acceptance.
- Leave tap_sel, state, fill_cnt and switch_cnt unchanged.
REQ-025 When ena=0, SHALL hold state, tap_sel, fill_cnt, out_valid and switch_cnt.
- No requests are accepted; sel_err = 0.
- FILL counting resumes where it stopped when ena returns.
REQ-026 When an accepted request and the FILL-complete condition occur in the same cycle, the request SHALL take priority.
- A legal change restarts FILL with out_valid = 0.
- An illegal or same-index request lets the completion proceed.
REQ-027 SHALL never let fill_cnt exceed DEPTH[tap_sel], nor wrap.

Reset
REQ-028 While rst_n=0, SHALL asynchronously force the following.
- state = FILL, tap_sel = 0, fill_cnt = 0, out_valid = 0, sel_err = 0, switch_cnt = 0.
- mute = 1.
REQ-029 After rst_n deasserts, SHALL start filling line 0 on the first enabled clk edge.
REQ-030 Reset asserted mid-FILL or mid-RUN SHALL discard the in-progress fill and any pending request.

Verification
REQ-031 Reset, then ena=1 with no requests -> out_valid=0 and mute=1 for 30 cycles; out_valid=1 on cycle 30; fill_cnt=30 thereafter.
REQ-032 In RUN on line 0, accept sel_req=3 -> tap_sel=3, switch_cnt=1, mute=1 for 90 cycles, then out_valid=1.
REQ-033 In RUN on line 2, accept sel_req=2 -> no change: out_valid stays 1, switch_cnt unchanged. Then accept sel_req=9 -> sel_err pulses one cycle, tap_sel remains 2.
REQ-034 FILL of line 1 with ena dropped for 10 cycles at fill_cnt=20 -> fill_cnt holds at 20 and mute=1; out_valid rises 45 enabled cycles (55 total) after FILL entry.
REQ-035 Request sel_req=1 on the exact cycle fill_cnt=29 on line 0 -> FILL restarts on line 1 with fill_cnt=0; out_valid never asserts for line 0.
REQ-036 Assert rst_n=0 mid-FILL of line 3 at fill_cnt=50 -> outputs reach reset values immediately without a clk edge; the next fill is on line 0, lasting 30 cycles.
